mm3_stream_loader: RTL and testbench
====================================

Name: mm3_stream_loader

Overview:
Upstream feeder for the 3x3 matrix multiplier. It accepts one valid/ready element stream carrying matrix A (M*N elements, row-major) followed by matrix B (N*P elements, row-major), and writes each element into the multiplier's A/B load ports. It then holds the multiplier's start input until the multiplier reports done, and reports job completion, framing errors and watchdog timeouts upstream.

Parameters:
M, 3, rows of A and C
N, 3, cols of A / rows of B
P, 3, cols of B and C
DATA_WIDTH, 32, signed element width
ADDR_WIDTH, 4, load address width (must hold max(M*N, N*P)-1)
TIMEOUT, 1024, max cycles in RUN before abort

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
s_data  in  DATA_WIDTH  stream element (signed)
s_valid  in  1  element valid
s_last  in  1  marks final B element of a job
s_ready  out  1  loader accepts element
a_in  out  DATA_WIDTH  A element to multiplier
a_addr  out  ADDR_WIDTH  A load address
a_wen  out  1  A write enable
b_in  out  DATA_WIDTH  B element to multiplier
b_addr  out  ADDR_WIDTH  B load address
b_wen  out  1  B write enable
start  out  1  multiplier start (level)
mm_done  in  1  multiplier done
busy  out  1  high from first accepted beat until job end
job_done  out  1  one-cycle completion pulse
frame_err  out  1  one-cycle framing error pulse
timeout  out  1  one-cycle watchdog pulse

Behaviour:
- Reset (async, rst=1): state LOAD_A, idx=0, wdog=0. All outputs 0 except s_ready=1. a_in, b_in, a_addr and b_addr are 0.
- Beat = s_valid & s_ready. s_ready=1 only in LOAD_A and LOAD_B.
- Write latency is 1 cycle. The A write for a beat appears on the next clock: a_wen=1, a_addr=idx, a_in=s_data. B writes behave the same way. The wen signals are single-cycle. Addr and data hold their last values when wen=0.
- LOAD_A: on each beat, write A[idx].
  - s_last=1 on any A beat: the beat is discarded (no wen), frame_err pulses, idx=0, and the state stays LOAD_A.
  - On an accepted beat with idx=M*N-1: idx=0 and go to LOAD_B.
- LOAD_B: on each beat, write B[idx].
  - s_last=1 with idx<N*P-1, or s_last=0 with idx=N*P-1: the beat is discarded, frame_err pulses, idx=0, and the state returns to LOAD_A (the whole job restarts).
  - Correct final beat: the write is issued and the state goes to RUN.
- RUN: start=1, registered, asserted the cycle after the final B write.
  - wdog increments each cycle.
  - mm_done=1: start=0 next cycle, job_done pulses that same next cycle, go to RELEASE.
  - wdog reaches TIMEOUT-1 without mm_done: start=0, timeout pulses, go to RELEASE. job_done does not pulse.
- RELEASE: start=0, s_ready=0. Wait for mm_done=0, then go to LOAD_A with idx=0 and wdog=0.
- busy=1 from the cycle after the first A beat of a job until RELEASE exits. It drops on frame_err.
- Stalls: s_valid=0 never advances idx. Gaps between beats are allowed anywhere.
- mm_done=1 outside RUN is ignored.
- s_data is passed through unmodified; no arithmetic.
- Reset asserted mid-job clears all state immediately. Partial writes already issued are not undone.

Test Plan:
- Back-to-back stream: A=identity, B=1..9, s_last on beat 18 -> a_wen on 9 consecutive cycles at addr 0..8, then b_wen on 9 cycles with b_in=1..9. start rises 1 cycle after the last b_wen. Model mm_done 5 cycles later -> start falls next cycle with a single job_done pulse.
- Random s_valid gaps (50%) -> identical write sequence and addresses; s_ready low only in RUN/RELEASE.
- s_last on B beat 4 -> no b_wen for that beat, frame_err pulses once, next beat writes a_addr=0.
- Beat 18 without s_last -> frame_err, no start. Resend a full frame -> normal completion.
- mm_done never asserted, TIMEOUT=16 -> start high exactly 16 cycles, timeout pulses once, job_done stays 0. Loader returns to LOAD_A once mm_done=0.
- rst pulsed during LOAD_B beat 5 (async, mid-cycle) -> all outputs cleared immediately, s_ready=1. Next accepted beat writes a_addr=0.

Source files
------------

// File: rtl/mm3_stream_loader.sv
// Stream loader that feeds the 3x3 matrix multiplier. It writes A then B from one
// valid/ready stream, holds start until done, and reports done/framing/watchdog events.
module mm3_stream_loader #(
  parameter int M          = 3,
  parameter int N          = 3,
  parameter int P          = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  input  logic                         s_valid,
  input  logic                         s_last,
  output logic                         s_ready,
  output logic signed [DATA_WIDTH-1:0] a_in,
  output logic        [ADDR_WIDTH-1:0] a_addr,
  output logic                         a_wen,
  output logic signed [DATA_WIDTH-1:0] b_in,
  output logic        [ADDR_WIDTH-1:0] b_addr,
  output logic                         b_wen,
  output logic                         start,
  input  logic                         mm_done,
  output logic                         busy,
  output logic                         job_done,
  output logic                         frame_err,
  output logic                         timeout
);

  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] A_LAST    = ADDR_WIDTH'(M * N - 1);
  localparam logic [ADDR_WIDTH-1:0] B_LAST    = ADDR_WIDTH'(N * P - 1);
  localparam logic [WDOG_W-1:0]     WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, RUN, RELEASE} state_t;

  state_t                         r_state;
  state_t                         w_state_next;
  logic        [ADDR_WIDTH-1:0]   r_idx;
  logic        [WDOG_W-1:0]       r_wdog;
  logic signed [DATA_WIDTH-1:0]   r_a_in;
  logic        [ADDR_WIDTH-1:0]   r_a_addr;
  logic                           r_a_wen;
  logic signed [DATA_WIDTH-1:0]   r_b_in;
  logic        [ADDR_WIDTH-1:0]   r_b_addr;
  logic                           r_b_wen;
  logic                           r_start;
  logic                           r_busy;
  logic                           r_job_done;
  logic                           r_frame_err;
  logic                           r_timeout;

  logic w_beat;
  logic w_a_write;
  logic w_b_write;
  logic w_frame_err;
  logic w_job_done;
  logic w_timeout;
  logic w_idx_clr;
  logic w_idx_inc;
  logic w_start_next;

  assign s_ready = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign w_beat  = s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LOAD_A;
    else     r_state <= w_state_next;
  end

  // The watchdog only counts cycles where start is actually asserted.
  always_comb begin
    w_state_next = r_state;
    w_a_write    = 1'b0;
    w_b_write    = 1'b0;
    w_frame_err  = 1'b0;
    w_job_done   = 1'b0;
    w_timeout    = 1'b0;
    w_idx_clr    = 1'b0;
    w_idx_inc    = 1'b0;
    w_start_next = 1'b0;
    case (r_state)
      LOAD_A: begin
        if (w_beat) begin
          if (s_last) begin
            w_frame_err = 1'b1;
            w_idx_clr   = 1'b1;
          end else begin
            w_a_write = 1'b1;
            if (r_idx == A_LAST) begin
              w_idx_clr    = 1'b1;
              w_state_next = LOAD_B;
            end else begin
              w_idx_inc = 1'b1;
            end
          end
        end
      end
      LOAD_B: begin
        if (w_beat) begin
          if (s_last != (r_idx == B_LAST)) begin
            w_frame_err  = 1'b1;
            w_idx_clr    = 1'b1;
            w_state_next = LOAD_A;
          end else begin
            w_b_write = 1'b1;
            if (s_last) begin
              w_idx_clr    = 1'b1;
              w_state_next = RUN;
            end else begin
              w_idx_inc = 1'b1;
            end
          end
        end
      end
      RUN: begin
        if (mm_done) begin
          w_job_done   = 1'b1;
          w_state_next = RELEASE;
        end else if (r_start && (r_wdog == WDOG_LAST)) begin
          w_timeout    = 1'b1;
          w_state_next = RELEASE;
        end else begin
          w_start_next = 1'b1;
        end
      end
      RELEASE: begin
        if (!mm_done) w_state_next = LOAD_A;
      end
      default: w_state_next = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_wdog      <= '0;
      r_a_in      <= '0;
      r_a_addr    <= '0;
      r_a_wen     <= 1'b0;
      r_b_in      <= '0;
      r_b_addr    <= '0;
      r_b_wen     <= 1'b0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_job_done  <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_a_wen <= w_a_write;
      if (w_a_write) begin
        r_a_addr <= r_idx;
        r_a_in   <= s_data;
      end
      r_b_wen <= w_b_write;
      if (w_b_write) begin
        r_b_addr <= r_idx;
        r_b_in   <= s_data;
      end
      if (w_idx_clr)      r_idx <= '0;
      else if (w_idx_inc) r_idx <= r_idx + ADDR_WIDTH'(1);
      if (r_state != RUN)  r_wdog <= '0;
      else if (r_start)    r_wdog <= r_wdog + WDOG_W'(1);
      r_start     <= w_start_next;
      r_job_done  <= w_job_done;
      r_frame_err <= w_frame_err;
      r_timeout   <= w_timeout;
      // Busy covers a whole job and is dropped when the job aborts or releases.
      if (w_a_write)                               r_busy <= 1'b1;
      else if (w_frame_err)                        r_busy <= 1'b0;
      else if ((r_state == RELEASE) && !mm_done)   r_busy <= 1'b0;
    end
  end

  assign a_in      = r_a_in;
  assign a_addr    = r_a_addr;
  assign a_wen     = r_a_wen;
  assign b_in      = r_b_in;
  assign b_addr    = r_b_addr;
  assign b_wen     = r_b_wen;
  assign start     = r_start;
  assign busy      = r_busy;
  assign job_done  = r_job_done;
  assign frame_err = r_frame_err;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_mm3_stream_loader.sv
// Directed bench for mm3_stream_loader: a vector table for whole jobs and framing
// errors, plus hand sequences for stream gaps, watchdog timeout and mid-job reset.
module tb_mm3_stream_loader;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [DW-1:0] a_in;
  logic [AW-1:0] a_addr;
  logic          a_wen;
  logic [DW-1:0] b_in;
  logic [AW-1:0] b_addr;
  logic          b_wen;
  logic          start;
  logic          mm_done;
  logic          busy;
  logic          job_done;
  logic          frame_err;
  logic          timeout;

  always #5 clk = ~clk;

  mm3_stream_loader #(
    .M(3), .N(3), .P(3), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .a_in(a_in), .a_addr(a_addr), .a_wen(a_wen),
    .b_in(b_in), .b_addr(b_addr), .b_wen(b_wen),
    .start(start), .mm_done(mm_done), .busy(busy),
    .job_done(job_done), .frame_err(frame_err), .timeout(timeout)
  );

  typedef struct packed {
    logic          a_wen;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_in;
    logic          b_wen;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_in;
    logic          start;
    logic          s_ready;
    logic          busy;
    logic          job_done;
    logic          frame_err;
    logic          timeout;
  } outs_t;

  typedef struct {
    logic          valid;
    logic          last;
    logic          done;
    logic [DW-1:0] data;
    outs_t         exp;
    string         tag;
  } vec_t;

  vec_t  vecs[$];
  outs_t e;
  int    nCompared   = 0;
  int    nMismatched = 0;

  function automatic outs_t sampleOuts();
    return {a_wen, a_addr, a_in, b_wen, b_addr, b_in,
            start, s_ready, busy, job_done, frame_err, timeout};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic l, input logic d, input logic [DW-1:0] dat);
    s_valid = v;
    s_last  = l;
    mm_done = d;
    s_data  = dat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input string tag, input logic v, input logic l, input logic d,
                        input logic [DW-1:0] dat);
    vec_t t;
    t.valid = v; t.last = l; t.done = d; t.data = dat; t.exp = e; t.tag = tag;
    vecs.push_back(t);
  endtask

  task automatic clrPulses();
    e.a_wen = 0; e.b_wen = 0; e.job_done = 0; e.frame_err = 0; e.timeout = 0;
  endtask

  task automatic addAFrame(input bit identity, input int base);
    logic [DW-1:0] d;
    for (int k = 0; k < 9; k++) begin
      d = identity ? ((k % 4 == 0) ? 32'd1 : 32'd0) : DW'(base + k);
      clrPulses();
      e.a_wen = 1; e.a_addr = AW'(k); e.a_in = d; e.busy = 1; e.s_ready = 1;
      addVec("loadA", 1'b1, 1'b0, 1'b0, d);
    end
  endtask

  task automatic addBBeats(input int count, input int base);
    for (int k = 0; k < count; k++) begin
      clrPulses();
      e.b_wen = 1; e.b_addr = AW'(k); e.b_in = DW'(base + k);
      addVec("loadB", 1'b1, 1'b0, 1'b0, DW'(base + k));
    end
  endtask

  // A good job with mm_done arriving on the fifth cycle of start.
  task automatic addGoodJob(input bit identity, input int baseA, input int baseB);
    addAFrame(identity, baseA);
    addBBeats(8, baseB);
    clrPulses();
    e.b_wen = 1; e.b_addr = 4'd8; e.b_in = DW'(baseB + 8); e.s_ready = 0;
    addVec("lastB", 1'b1, 1'b1, 1'b0, DW'(baseB + 8));
    clrPulses();
    e.start = 1;
    for (int k = 0; k < 5; k++) addVec("run", 1'b0, 1'b0, 1'b0, '0);
    e.start = 0; e.job_done = 1;
    addVec("done", 1'b0, 1'b0, 1'b1, '0);
    clrPulses();
    addVec("release", 1'b0, 1'b0, 1'b1, '0);
    e.s_ready = 1; e.busy = 0;
    addVec("idle", 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    outs_t rv;
    int beats, cyc, cnt, jd;
    logic seenT, v;
    logic [DW-1:0] d;

    rv = '0; rv.s_ready = 1;
    e  = rv;

    addGoodJob(1'b1, 0, 1);
    clrPulses();
    addVec("doneIgnored", 1'b0, 1'b0, 1'b1, '0);

    addAFrame(1'b0, 'h10);
    addBBeats(3, 'h20);
    clrPulses();
    e.frame_err = 1; e.busy = 0;
    addVec("earlyLast", 1'b1, 1'b1, 1'b0, 32'h23);
    clrPulses();
    e.a_wen = 1; e.a_addr = 0; e.a_in = 32'h77; e.busy = 1;
    addVec("restartA0", 1'b1, 1'b0, 1'b0, 32'h77);
    clrPulses();
    e.frame_err = 1; e.busy = 0;
    addVec("lastOnA", 1'b1, 1'b1, 1'b0, 32'h99);

    addAFrame(1'b0, 'h30);
    addBBeats(8, 'h40);
    clrPulses();
    e.frame_err = 1; e.busy = 0;
    addVec("missingLast", 1'b1, 1'b0, 1'b0, 32'h48);
    clrPulses();
    addVec("noStart", 1'b0, 1'b0, 1'b0, '0);
    addGoodJob(1'b0, 'h50, 'h60);

    rst = 1;
    applyStimulus(0, 0, 0, '0);
    #12;
    checkOutput("resetState", sampleOuts(), rv);
    @(posedge clk);
    #1 rst = 0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].last, vecs[i].done, vecs[i].data);
      step();
      checkOutput($sformatf("%s[%0d]", vecs[i].tag, i), sampleOuts(), vecs[i].exp);
    end
    applyStimulus(0, 0, 0, '0);

    // Random gaps on the stream must not change the write sequence.
    beats = 0;
    cyc   = 0;
    while (beats < 18 && cyc < 400) begin
      v = 1'($urandom_range(0, 1));
      d = (beats < 9) ? DW'(100 + beats) : DW'(200 + beats - 9);
      applyStimulus(v, beats == 17, 0, d);
      step();
      cyc++;
      if (v) begin
        if (beats < 9) begin
          checkOutput("gapWen", {a_wen, b_wen}, 2'b10);
          checkOutput("gapAaddr", {a_addr, a_in}, {AW'(beats), d});
        end else begin
          checkOutput("gapWen", {a_wen, b_wen}, 2'b01);
          checkOutput("gapBaddr", {b_addr, b_in}, {AW'(beats - 9), d});
        end
        beats++;
      end else begin
        checkOutput("gapIdleWen", {a_wen, b_wen}, 2'b00);
      end
      checkOutput("gapReady", s_ready, (beats < 18) ? 1'b1 : 1'b0);
    end
    checkOutput("gapAllBeats", beats, 18);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, 32'hDEAD);
      step();
      checkOutput("runHold", {s_ready, a_wen, b_wen, start}, 4'b0001);
    end
    applyStimulus(0, 0, 1, '0);
    step();
    checkOutput("gapDone", {start, job_done, s_ready}, 3'b010);
    applyStimulus(0, 0, 0, '0);
    step();
    checkOutput("gapBackToLoad", {s_ready, busy}, 2'b10);

    // Watchdog: mm_done never arrives.
    for (int k = 0; k < 18; k++) begin
      applyStimulus(1, k == 17, 0, DW'(k));
      step();
    end
    applyStimulus(0, 0, 0, '0);
    cnt = 0; jd = 0; seenT = 0;
    for (int c = 0; c < 60 && !seenT; c++) begin
      step();
      if (start) cnt++;
      if (job_done) jd++;
      if (timeout) begin
        seenT = 1;
        checkOutput("toStartLow", start, 1'b0);
      end
    end
    checkOutput("toSeen", seenT, 1'b1);
    checkOutput("toStartCycles", cnt, 16);
    checkOutput("toJobDone", jd, 0);
    applyStimulus(0, 0, 1, '0);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("toRelease", {s_ready, timeout, job_done, start}, 4'b0000);
    end
    applyStimulus(0, 0, 0, '0);
    step();
    checkOutput("toBackToLoad", {s_ready, busy}, 2'b10);

    // Asynchronous reset in the middle of a B beat.
    for (int k = 0; k < 13; k++) begin
      applyStimulus(1, 0, 0, DW'(k + 1));
      step();
    end
    applyStimulus(1, 0, 0, 32'hBEEF);
    #2 rst = 1;
    #1;
    checkOutput("midReset", sampleOuts(), rv);
    applyStimulus(0, 0, 0, '0);
    @(posedge clk);
    #1 rst = 0;
    applyStimulus(1, 0, 0, 32'hCAFE);
    step();
    e = rv; e.a_wen = 1; e.a_addr = 0; e.a_in = 32'hCAFE; e.busy = 1;
    checkOutput("afterReset", sampleOuts(), e);
    applyStimulus(0, 0, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
